// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared memory-read FSM encodings and default fetch widths
package fetch_pkg;

    localparam int WORD_SIZE = 32;
    localparam int ADDR_SIZE = 16;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_REQ  = 2'd1,
        M_DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_read_handshake.sv
// rtl/mem_read_handshake.sv - instruction-memory read FSM with request timeout
module mem_read_handshake
    import fetch_pkg::*;
#(
    parameter int timeout_cycles = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic load_mem,
    input  logic mem_ack,
    output logic mem_req,
    output logic start,
    output logic overrun,
    output logic capture,
    output logic timeout,
    output logic busy,
    output logic fetch_wait
);

    localparam int CW = $clog2(timeout_cycles + 1);

    mem_state_t    state;
    logic [CW-1:0] count;
    logic [CW-1:0] count_inc;

    assign count_inc  = count + 1'b1;
    assign busy       = (state == M_REQ);
    assign start      = load_mem && !busy;
    assign overrun    = load_mem && busy;
    assign capture    = busy && mem_ack;
    // An ack in the final allowed cycle wins over the abort.
    assign timeout    = busy && !mem_ack && (count_inc == CW'(timeout_cycles));
    assign fetch_wait = busy || start;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= M_IDLE;
            count   <= '0;
            mem_req <= 1'b0;
        end else begin
            case (state)
                M_IDLE, M_DONE: begin
                    if (load_mem) begin
                        state   <= M_REQ;
                        count   <= '0;
                        mem_req <= 1'b1;
                    end else begin
                        state   <= M_IDLE;
                    end
                end
                M_REQ: begin
                    if (mem_ack || timeout) begin
                        state   <= M_DONE;
                        mem_req <= 1'b0;
                    end else begin
                        count   <= count_inc;
                    end
                end
                default: begin
                    state   <= M_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC/AR/MDR/IR datapath feeding the control unit
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int word_size      = WORD_SIZE,
    parameter int addr_size      = ADDR_SIZE,
    parameter int reset_vector   = 0,
    parameter int timeout_cycles = 15
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load_ar,
    input  logic                 load_ar_i,
    input  logic                 load_pc_i,
    input  logic                 increment_pc,
    input  logic                 load_mem,
    input  logic                 load_ir,
    input  logic [addr_size-1:0] target_addr,
    input  logic [word_size-1:0] mem_rdata,
    input  logic                 mem_ack,
    output logic                 mem_req,
    output logic [addr_size-1:0] mem_addr,
    output logic [word_size-1:0] instruction,
    output logic [addr_size-1:0] pc,
    output logic                 fetch_wait,
    output logic                 bus_error
);

    logic [addr_size-1:0] ar;
    logic [addr_size-1:0] ar_next;
    logic [word_size-1:0] mdr;
    logic                 start;
    logic                 overrun;
    logic                 capture;
    logic                 timeout;
    logic                 busy;

    mem_read_handshake #(
        .timeout_cycles (timeout_cycles)
    ) u_handshake (
        .clock      (clock),
        .reset      (reset),
        .load_mem   (load_mem),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .start      (start),
        .overrun    (overrun),
        .capture    (capture),
        .timeout    (timeout),
        .busy       (busy),
        .fetch_wait (fetch_wait)
    );

    always_comb begin
        ar_next = ar;
        if (load_ar_i)
            ar_next = target_addr;
        else if (load_ar)
            ar_next = pc;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc          <= addr_size'(reset_vector);
            ar          <= '0;
            mdr         <= '0;
            instruction <= '0;
            mem_addr    <= '0;
            bus_error   <= 1'b0;
        end else begin
            if (load_pc_i)
                pc <= target_addr;
            else if (increment_pc)
                pc <= pc + 1'b1;

            ar <= ar_next;

            // Latch the request address so AR may change while a read is in flight.
            if (start)
                mem_addr <= ar_next;

            if (capture)
                mdr <= mem_rdata;
            else if (timeout)
                mdr <= '0;

            if (load_ir)
                instruction <= mdr;

            if (timeout || overrun || (load_ir && busy))
                bus_error <= 1'b1;
        end
    end

endmodule
